// File: rtl/rsa_job_arbiter_if.sv
// Host request/response ports and engine pins of the RSA job arbiter.
// slave = arbiter side, master = requesters + engine side.
interface rsa_job_arbiter_if #(
    parameter int DATA_W   = 8,
    parameter int RESULT_W = 16
);
    logic                req0_valid, req1_valid;
    logic [DATA_W-1:0]   req0_data, req1_data;
    logic                req0_ready, req1_ready;
    logic                rsp0_valid, rsp1_valid;
    logic [RESULT_W-1:0] rsp0_data, rsp1_data;
    logic                rsp0_err, rsp1_err;
    logic                rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0]   eng_data;
    logic                eng_start;
    logic                eng_done;
    logic [RESULT_W-1:0] eng_result;

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        input  rsp0_ready, rsp1_ready, eng_done, eng_result,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp0_data, rsp1_data, rsp0_err, rsp1_err,
        output eng_data, eng_start
    );

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        output rsp0_ready, rsp1_ready, eng_done, eng_result,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp0_data, rsp1_data, rsp0_err, rsp1_err,
        input  eng_data, eng_start
    );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin two-requester front end for a single RSA modexp engine.
// Define RSA_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts jobs with rsp_err.
module rsa_job_arbiter #(
    parameter int DATA_W         = 8,
    parameter int RESULT_W       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    rsa_job_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_n;
    logic                prio, owner, wait_first;
    logic [DATA_W-1:0]   job_data;
    logic [RESULT_W-1:0] res_q;
    logic                err_q;

    logic sel, sel_valid;
    logic accept, capture, expire, rsp_done, tmo_hit;

    // Prefer the prio side; fall over to the other side only if prio is idle.
    always_comb begin
        if (prio == 1'b0) sel = !bus.req0_valid && bus.req1_valid;
        else              sel = bus.req1_valid || !bus.req0_valid;
        sel_valid = sel ? bus.req1_valid : bus.req0_valid;
    end

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (state == ISSUE) cnt <= '0;
        else if (state == WAIT)  cnt <= cnt + 1'b1;
    end

    assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        accept         = 1'b0;
        capture        = 1'b0;
        expire         = 1'b0;
        rsp_done       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.eng_start  = 1'b0;
        case (state)
            IDLE: if (!rst) begin
                bus.req0_ready = !sel;
                bus.req1_ready = sel;
                if (sel_valid) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                bus.eng_start = 1'b1;
                state_n       = WAIT;
            end
            // A done in the first WAIT cycle may belong to the previous job.
            WAIT: begin
                if (bus.eng_done && !wait_first) begin
                    capture = 1'b1;
                    state_n = RESP;
                end else if (tmo_hit) begin
                    expire  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rsp_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            wait_first <= 1'b0;
            job_data   <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            wait_first <= (state == ISSUE);
            if (accept) begin
                job_data <= sel ? bus.req1_data : bus.req0_data;
                owner    <= sel;
            end
            if (capture) begin
                res_q <= bus.eng_result;
                err_q <= 1'b0;
            end else if (expire) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
            if (rsp_done) prio <= ~owner;
        end
    end

    logic in_resp;
    assign in_resp        = (state == RESP);
    assign bus.rsp0_valid = in_resp && !owner;
    assign bus.rsp1_valid = in_resp && owner;
    assign bus.rsp0_data  = bus.rsp0_valid ? res_q : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? res_q : '0;
    assign bus.rsp0_err   = bus.rsp0_valid && err_q;
    assign bus.rsp1_err   = bus.rsp1_valid && err_q;
    assign bus.eng_data   = job_data;
endmodule
